uart_tx_fifo: RTL and testbench

Parametrised UART transmitter, successor to the fixed 8-bit UART_TOP transmit path. It adds a configurable data width, a runtime baud prescaler, one or two stop bits, and an input FIFO. Frames are sent back-to-back with no idle gap while data is queued. It sits between a parallel producer (valid/ready handshake) and the serial line pin.

---
 rtl/uart_tx_fifo.sv | 155 +++++++++++++++
 tb/tb_uart_tx_fifo.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo
// Description : UART transmitter with input FIFO, runtime prescaler, optional
//               parity and one/two stop bits; frames sent back-to-back.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int DATA_WIDTH  = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int PRESC_WIDTH = 8
) (
    input  logic                            CLK,
    input  logic                            RST,
    input  logic [DATA_WIDTH-1:0]           P_DATA,
    input  logic                            data_valid,
    output logic                            data_ready,
    input  logic                            party_en,
    input  logic                            party_typ,
    input  logic                            stop2,
    input  logic [PRESC_WIDTH-1:0]          prescale,
    output logic                            Tx_OUT,
    output logic                            busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);

    localparam int c_ADDR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int c_IDX_W  = $clog2(DATA_WIDTH);

    localparam logic [c_CNT_W-1:0] c_FULL     = c_CNT_W'(FIFO_DEPTH);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(DATA_WIDTH - 1);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_START  = 3'd1;
    localparam logic [2:0] c_DATA   = 3'd2;
    localparam logic [2:0] c_PARITY = 3'd3;
    localparam logic [2:0] c_STOP   = 3'd4;

    logic [DATA_WIDTH-1:0]  r_mem [FIFO_DEPTH];
    logic [c_ADDR_W-1:0]    r_wr_ptr, r_rd_ptr;
    logic [c_CNT_W-1:0]     r_count;
    logic [2:0]             r_state, w_state_next;
    logic [DATA_WIDTH-1:0]  r_shift, w_shift_next;
    logic                   r_par, r_par_en, r_par_typ, r_stop2;
    logic [PRESC_WIDTH-1:0] r_presc, r_cnt;
    logic [c_IDX_W-1:0]     r_idx;
    logic                   r_tx, r_busy, w_tx_next;
    logic                   w_push, w_pop, w_fifo_empty, w_bit_end, w_last_stop;

    assign data_ready   = (r_count != c_FULL);
    assign w_push       = data_valid && data_ready;
    assign w_fifo_empty = (r_count == '0);
    assign w_bit_end    = (r_cnt == r_presc - PRESC_WIDTH'(1));
    assign w_last_stop  = (r_state == c_STOP) && w_bit_end &&
                          (r_idx == {{(c_IDX_W-1){1'b0}}, r_stop2});
    // Pop from IDLE or straight out of the final stop bit, so no idle gap appears.
    assign w_pop        = !w_fifo_empty && ((r_state == c_IDLE) || w_last_stop);

    assign Tx_OUT     = r_tx;
    assign busy       = r_busy;
    assign fifo_count = r_count;

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= P_DATA;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_ADDR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ADDR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= c_IDLE;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_tx    <= w_tx_next;
            r_busy  <= (w_state_next != c_IDLE);
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE:   if (!w_fifo_empty) w_state_next = c_START;
            c_START:  if (w_bit_end) w_state_next = c_DATA;
            c_DATA:   if (w_bit_end && (r_idx == c_LAST_IDX))
                          w_state_next = r_par_en ? c_PARITY : c_STOP;
            c_PARITY: if (w_bit_end) w_state_next = c_STOP;
            c_STOP:   if (w_last_stop)
                          w_state_next = w_fifo_empty ? c_IDLE : c_START;
            default:  w_state_next = c_IDLE;
        endcase
    end

    // Line level is computed for the upcoming state so Tx_OUT can be a flop.
    always_comb begin
        w_shift_next = r_shift;
        if ((r_state == c_DATA) && w_bit_end) begin
            w_shift_next = r_shift >> 1;
        end
        case (w_state_next)
            c_START:  w_tx_next = 1'b0;
            c_DATA:   w_tx_next = w_shift_next[0];
            c_PARITY: w_tx_next = r_par ^ r_par_typ;
            default:  w_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_shift   <= '0;
            r_par     <= 1'b0;
            r_par_en  <= 1'b0;
            r_par_typ <= 1'b0;
            r_stop2   <= 1'b0;
            r_presc   <= '0;
            r_cnt     <= '0;
            r_idx     <= '0;
        end else begin
            r_shift <= w_pop ? r_mem[r_rd_ptr] : w_shift_next;
            if (w_pop) begin
                r_par     <= ^r_mem[r_rd_ptr];
                r_par_en  <= party_en;
                r_par_typ <= party_typ;
                r_stop2   <= stop2;
                r_presc   <= (prescale == '0) ? PRESC_WIDTH'(1) : prescale;
            end
            r_cnt <= ((r_state == c_IDLE) || w_bit_end) ? '0 : r_cnt + PRESC_WIDTH'(1);
            if (w_state_next != r_state) begin
                r_idx <= '0;
            end else if (w_bit_end && (r_state != c_IDLE)) begin
                r_idx <= r_idx + c_IDX_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_fifo
// Description : Directed self-checking bench for uart_tx_fifo.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

    logic       CLK;
    logic       RST;
    logic [7:0] P_DATA;
    logic       data_valid;
    logic       data_ready;
    logic       party_en;
    logic       party_typ;
    logic       stop2;
    logic [7:0] prescale;
    logic       Tx_OUT;
    logic       busy;
    logic [2:0] fifo_count;

    int total = 0;
    int bad   = 0;

    uart_tx_fifo #(
        .DATA_WIDTH (8),
        .FIFO_DEPTH (4),
        .PRESC_WIDTH(8)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .P_DATA    (P_DATA),
        .data_valid(data_valid),
        .data_ready(data_ready),
        .party_en  (party_en),
        .party_typ (party_typ),
        .stop2     (stop2),
        .prescale  (prescale),
        .Tx_OUT    (Tx_OUT),
        .busy      (busy),
        .fifo_count(fifo_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        if (obs !== exp_v) begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Push one word into an idle DUT, then follow the whole frame cycle by cycle.
    task automatic run_frame(input logic [7:0] d, input logic pe, input logic pt,
                             input logic s2, input int p, input logic exp_par,
                             input logic toggle, input string tag);
        logic [11:0] bits;
        int          n;
        party_en   = pe;
        party_typ  = pt;
        stop2      = s2;
        prescale   = 8'(p);
        P_DATA     = d;
        data_valid = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        data_valid = 1'b0;
        chk({tag, " count after push"}, fifo_count, 3'd1);
        chk({tag, " busy before pop"}, busy, 1'b0);
        bits    = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[1+i] = d[i];
        n = 9;
        if (pe) begin
            bits[9] = exp_par;
            n = 10;
        end
        n = n + 1 + int'(s2);
        for (int c = 0; c < n * p; c++) begin
            @(negedge CLK);
            chk({tag, " tx"}, Tx_OUT, bits[c/p]);
            chk({tag, " busy"}, busy, 1'b1);
            if (toggle && (c == 3 * p)) party_typ = ~party_typ;
        end
        @(negedge CLK);
        chk({tag, " busy after frame"}, busy, 1'b0);
        chk({tag, " tx after frame"}, Tx_OUT, 1'b1);
        chk({tag, " count after frame"}, fifo_count, 3'd0);
    endtask

    initial begin
        int         nxt;
        logic       acc;
        logic       saw_full;
        logic       exp_bit;
        logic [7:0] d;
        int         f;
        int         b;

        RST        = 1'b1;
        P_DATA     = 8'h00;
        data_valid = 1'b0;
        party_en   = 1'b0;
        party_typ  = 1'b0;
        stop2      = 1'b0;
        prescale   = 8'd1;

        // Reset state, then a quiet line with nothing queued
        repeat (2) @(negedge CLK);
        chk("rst tx", Tx_OUT, 1'b1);
        chk("rst busy", busy, 1'b0);
        chk("rst ready", data_ready, 1'b1);
        chk("rst count", fifo_count, 3'd0);
        RST = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            chk("idle tx", Tx_OUT, 1'b1);
        end

        // 0x33, no parity, P=1: 0,1,1,0,0,1,1,0,0,1
        run_frame(8'h33, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0, "np33");
        // 0x17, odd parity, P=4: four ones -> parity bit 1; party_typ toggled mid-frame
        run_frame(8'h17, 1'b1, 1'b1, 1'b0, 4, 1'b1, 1'b1, "odd17");
        // 0xB3, even parity, two stops, P=2: five ones -> parity bit 1, 24 cycles
        run_frame(8'hB3, 1'b1, 1'b0, 1'b1, 2, 1'b1, 1'b0, "even_b3");
        // prescale 0 behaves as 1
        run_frame(8'h80, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0, "presc0_ref");

        // Fill and drain: 0x01..0x06 at P=8, 80 cycles per frame, no gaps
        party_en   = 1'b0;
        party_typ  = 1'b0;
        stop2      = 1'b0;
        prescale   = 8'd8;
        nxt        = 1;
        P_DATA     = 8'h01;
        data_valid = 1'b1;
        saw_full   = 1'b0;
        for (int k = -1; k <= 480; k++) begin
            acc = data_valid && data_ready;
            @(posedge CLK);
            @(negedge CLK);
            if (acc) nxt++;
            if (nxt <= 6) P_DATA = 8'(nxt);
            else          data_valid = 1'b0;
            if (fifo_count == 3'd4) begin
                saw_full = 1'b1;
                chk("full ready", data_ready, 1'b0);
            end
            if (k >= 0 && k < 480) begin
                f = k / 80;
                b = (k % 80) / 8;
                d = 8'(f + 1);
                if (b == 0)      exp_bit = 1'b0;
                else if (b == 9) exp_bit = 1'b1;
                else             exp_bit = d[b-1];
                chk("drain tx", Tx_OUT, exp_bit);
                chk("drain busy", busy, 1'b1);
            end else if (k == 480) begin
                chk("drain busy end", busy, 1'b0);
                chk("drain tx end", Tx_OUT, 1'b1);
            end
        end
        chk("drain reached full", saw_full, 1'b1);
        chk("drain pushes", nxt, 7);

        // Asynchronous reset during data bit 3 of 0xA5 with two words queued
        prescale   = 8'd4;
        P_DATA     = 8'hA5;
        data_valid = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        P_DATA = 8'h11;
        @(posedge CLK);
        @(negedge CLK);
        P_DATA = 8'h22;
        @(posedge CLK);
        @(negedge CLK);
        data_valid = 1'b0;
        repeat (16) @(negedge CLK);
        chk("midrst count before", fifo_count, 3'd2);
        chk("midrst data bit3", Tx_OUT, 1'b0);
        RST = 1'b1;
        #1;
        chk("midrst tx", Tx_OUT, 1'b1);
        chk("midrst busy", busy, 1'b0);
        chk("midrst count", fifo_count, 3'd0);
        chk("midrst ready", data_ready, 1'b1);
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK);
            chk("post rst tx", Tx_OUT, 1'b1);
            chk("post rst busy", busy, 1'b0);
        end

        // prescale 0 gives the same 10-cycle frame as P=1
        prescale   = 8'd0;
        P_DATA     = 8'h80;
        data_valid = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        data_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge CLK);
            chk("presc0 tx", Tx_OUT, (c == 0) ? 1'b0 : ((c == 8 || c == 9) ? 1'b1 : 1'b0));
            chk("presc0 busy", busy, 1'b1);
        end
        @(negedge CLK);
        chk("presc0 busy end", busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
